id_hazard_scoreboard: RTL and testbench

//  Per-register scoreboard for the ID stage. Replaces fixed EX/MEM load-use compare logic.

---
 rtl/id_hazard_scoreboard.sv | 73 +++++++
 tb/tb_id_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - per-register hazard scoreboard driving the ID stall and issue handshake
// Each register holds a countdown of cycles until its result is forwardable; all-ones marks a variable-latency producer.
module id_hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int IDX_W       = 5,
  parameter int LAT_W       = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid_in,
  input  logic [IDX_W-1:0]       issue_ra_idx,
  input  logic [IDX_W-1:0]       issue_rb_idx,
  input  logic                   issue_use_ra,
  input  logic                   issue_use_rb,
  input  logic                   issue_wr,
  input  logic [IDX_W-1:0]       issue_rd_idx,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic                   cmpl_valid,
  input  logic [IDX_W-1:0]       cmpl_idx,
  output logic                   stall_out,
  output logic                   issue_fire_out,
  output logic [NUM_REGS-1:0]    busy_vec_out,
  output logic [STALL_CNT_W-1:0] stall_cycles_out
);

  localparam logic [LAT_W-1:0] LAT_VAR = '1;

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             ra_busy;
  logic             rb_busy;

  // Decided from registered state only, so a same-cycle completion still stalls.
  assign ra_busy        = issue_use_ra && (issue_ra_idx != '0) && (cnt[issue_ra_idx] != '0);
  assign rb_busy        = issue_use_rb && (issue_rb_idx != '0) && (cnt[issue_rb_idx] != '0);
  assign stall_out      = issue_valid_in && (ra_busy || rb_busy);
  assign issue_fire_out = issue_valid_in && !stall_out;

  always_comb begin
    busy_vec_out = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_vec_out[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_fire_out && issue_wr && (issue_rd_idx == IDX_W'(r))) begin
          cnt[r] <= issue_lat;
        end else if (cmpl_valid && (cmpl_idx == IDX_W'(r)) && (cnt[r] == LAT_VAR)) begin
          cnt[r] <= '0;
        end else if ((cnt[r] != '0) && (cnt[r] != LAT_VAR)) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_out <= '0;
    end else if (stall_out && (stall_cycles_out != '1)) begin
      stall_cycles_out <= stall_cycles_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid_in, issue_use_ra, issue_use_rb, issue_wr, cmpl_valid;
  logic [4:0]  issue_ra_idx, issue_rb_idx, issue_rd_idx, cmpl_idx;
  logic [2:0]  issue_lat;
  logic        stall_out, issue_fire_out, stall_s, fire_s;
  logic [31:0] busy_vec_out, busy_s, stall_cycles_out;
  logic [3:0]  stall_cycles_s;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid_in(issue_valid_in),
    .issue_ra_idx(issue_ra_idx), .issue_rb_idx(issue_rb_idx),
    .issue_use_ra(issue_use_ra), .issue_use_rb(issue_use_rb),
    .issue_wr(issue_wr), .issue_rd_idx(issue_rd_idx), .issue_lat(issue_lat),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .stall_out(stall_out), .issue_fire_out(issue_fire_out),
    .busy_vec_out(busy_vec_out), .stall_cycles_out(stall_cycles_out)
  );

  id_hazard_scoreboard #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid_in(issue_valid_in),
    .issue_ra_idx(issue_ra_idx), .issue_rb_idx(issue_rb_idx),
    .issue_use_ra(issue_use_ra), .issue_use_rb(issue_use_rb),
    .issue_wr(issue_wr), .issue_rd_idx(issue_rd_idx), .issue_lat(issue_lat),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .stall_out(stall_s), .issue_fire_out(fire_s),
    .busy_vec_out(busy_s), .stall_cycles_out(stall_cycles_s)
  );

  localparam int K_STALL = 0, K_FIRE = 1, K_BUSY = 2, K_SC = 3, K_SC_SAT = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_STALL: act = {31'd0, stall_out};
        K_FIRE:  act = {31'd0, issue_fire_out};
        K_BUSY:  act = busy_vec_out;
        K_SC:    act = stall_cycles_out;
        default: act = {28'd0, stall_cycles_s};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic idle();
    issue_valid_in = 0; issue_use_ra = 0; issue_use_rb = 0; issue_wr = 0;
    issue_ra_idx = 0; issue_rb_idx = 0; issue_rd_idx = 0; issue_lat = 0;
    cmpl_valid = 0; cmpl_idx = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    issue_valid_in = 1; issue_wr = 1; issue_rd_idx = rd; issue_lat = lat;
  endtask

  task automatic dep_a(input logic [4:0] ra);
    issue_valid_in = 1; issue_use_ra = 1; issue_ra_idx = ra;
  endtask

  task automatic dep_b(input logic [4:0] rb);
    issue_valid_in = 1; issue_use_rb = 1; issue_rb_idx = rb;
  endtask

  task automatic cmpl(input logic [4:0] idx);
    cmpl_valid = 1; cmpl_idx = idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    // Reset state, with a valid instruction presented during reset
    step();
    dep_a(5'd5);
    push("rst_stall", K_STALL, 0);
    push("rst_fire", K_FIRE, 1);
    push("rst_busy", K_BUSY, 0);
    push("rst_sc", K_SC, 0);
    step();
    rst = 0;

    // T1 fixed latency
    issue(5'd5, 3'd2);
    push("t1_prod_fire", K_FIRE, 1);
    step(); dep_a(5'd5);
    push("t1_stall1", K_STALL, 1); push("t1_busy1", K_BUSY, 32'h20);
    step(); dep_a(5'd5);
    push("t1_stall2", K_STALL, 1); push("t1_busy2", K_BUSY, 32'h20);
    step(); dep_a(5'd5);
    push("t1_fire", K_FIRE, 1); push("t1_busy3", K_BUSY, 0); push("t1_sc", K_SC, 2);

    // T2 variable latency
    step(); rst = 1;
    step(); rst = 0;
    issue(5'd7, 3'd7);
    push("t2_prod_fire", K_FIRE, 1);
    for (int i = 0; i < 20; i++) begin
      step(); dep_b(5'd7);
      if (i == 19) cmpl(5'd7);
      push("t2_stall", K_STALL, 1);
      push("t2_busy", K_BUSY, 32'h80);
    end
    step(); dep_b(5'd7);
    push("t2_fire", K_FIRE, 1); push("t2_sc", K_SC, 20); push("t2_sc_sat", K_SC_SAT, 15);

    // T3 issue beats completion on the same register
    step(); issue(5'd7, 3'd7);
    step(); issue(5'd7, 3'd3); cmpl(5'd7);
    push("t3_fire", K_FIRE, 1);
    step(); cmpl(5'd7);
    push("t3_busy_after", K_BUSY, 32'h80);
    step(); push("t3_busy_dec2", K_BUSY, 32'h80);
    step(); push("t3_busy_dec1", K_BUSY, 32'h80);
    step(); push("t3_busy_clear", K_BUSY, 0);

    // T4 x0 and unused sources
    step(); issue(5'd0, 3'd7);
    push("t4_x0_fire", K_FIRE, 1);
    step(); dep_a(5'd0);
    push("t4_x0_busy", K_BUSY, 0); push("t4_ra0_stall", K_STALL, 0); push("t4_ra0_fire", K_FIRE, 1);
    step(); issue(5'd9, 3'd7);
    step(); dep_a(5'd0); issue_rb_idx = 5'd9;
    push("t4_unused_rb_stall", K_STALL, 0); push("t4_unused_rb_fire", K_FIRE, 1);
    push("t4_busy9", K_BUSY, 32'h200);
    step(); dep_b(5'd9);
    push("t4_used_rb_stall", K_STALL, 1);

    // T5 asynchronous reset mid-operation
    step(); issue(5'd3, 3'd7);
    push("t5_prod3_fire", K_FIRE, 1);
    step(); issue(5'd9, 3'd4);
    push("t5_waw_fire", K_FIRE, 1);
    step(); dep_a(5'd3);
    push("t5_busy_pre", K_BUSY, 32'h208); push("t5_stall_pre", K_STALL, 1);
    step(); dep_a(5'd3);
    #2 rst = 1;
    push("t5_busy_rst", K_BUSY, 0); push("t5_stall_rst", K_STALL, 0);
    push("t5_fire_rst", K_FIRE, 1); push("t5_sc_rst", K_SC, 0);
    step(); rst = 0; dep_a(5'd3);
    push("t5_stall_post", K_STALL, 0); push("t5_busy_post", K_BUSY, 0);

    // T6 counter saturation on the 4-bit instance
    step(); issue(5'd12, 3'd7);
    for (int i = 0; i < 20; i++) begin
      step(); dep_a(5'd12);
      push("t6_stall", K_STALL, 1);
      push("t6_sc", K_SC, 32'(i));
      push("t6_sc_sat", K_SC_SAT, (i > 15) ? 32'd15 : 32'(i));
    end
    step(); dep_a(5'd12); cmpl(5'd12);
    push("t6_sc20", K_SC, 20); push("t6_sat20", K_SC_SAT, 15);
    step(); dep_a(5'd12);
    push("t6_fire", K_FIRE, 1); push("t6_sc21", K_SC, 21); push("t6_sat21", K_SC_SAT, 15);

    step();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
